// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the instruction loader.
// The loader attaches to the slave modport. The stream source and the RAM attach to the master modport.
interface inst_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_loader.sv
// Instruction-memory loader. It assembles big-endian words from a byte stream and writes them to the RAM.
// It checks a trailing XOR checksum and holds the CPU in reset while the load is in progress.
module inst_loader #(
    parameter int ADDR_W = 8   // 1..8; the header byte carries the word count
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    inst_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE} state_t;

    state_t            state;
    logic [ADDR_W:0]   remain;
    logic [1:0]        bcnt;
    logic [7:0]        csum;
    logic              xfer;
    logic [ADDR_W-1:0] hdr_n;

    assign xfer  = bus.in_valid && bus.in_ready;
    assign hdr_n = bus.in_data[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            remain       <= '0;
            bcnt         <= '0;
            csum         <= '0;
            bus.in_ready <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    err          <= 1'b0;
                    cpu_hold     <= 1'b1;
                    csum         <= '0;
                    bus.in_ready <= 1'b1;
                    state        <= HDR;
                end
                HDR: if (xfer) begin
                    // A count field of zero means the full memory depth.
                    remain      <= (hdr_n == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, hdr_n};
                    csum        <= csum ^ bus.in_data;
                    bus.wr_addr <= '0;
                    bcnt        <= '0;
                    state       <= DATA;
                end
                DATA: if (xfer) begin
                    bus.wr_data <= {bus.wr_data[23:0], bus.in_data};
                    csum        <= csum ^ bus.in_data;
                    bcnt        <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        bus.in_ready <= 1'b0;
                        bus.wr_en    <= 1'b1;
                        state        <= WRITE;
                    end
                end
                WRITE: begin
                    bus.wr_en    <= 1'b0;
                    bus.wr_addr  <= bus.wr_addr + ADDR_W'(1);
                    remain       <= remain - (ADDR_W+1)'(1);
                    bus.in_ready <= 1'b1;
                    state        <= (remain == (ADDR_W+1)'(1)) ? CSUM : DATA;
                end
                CSUM: if (xfer) begin
                    err          <= (csum ^ bus.in_data) != 8'h00;
                    bus.in_ready <= 1'b0;
                    done         <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader. It runs table-driven loads, randomized loads and hand-written corner sequences.
module tb_inst_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, err;

    inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit loading = 1'b0;
    bit stalled = 1'b0;
    logic [31:0]        wq[$];
    logic [ADDR_W+31:0] wr_log[$];

    typedef struct {
        logic [7:0]        hdr;
        logic [7:0]        flip;
        int                gap;
        int                pat;       // 0 random words, 1 word=index, 2 nominal program
        int                mid;       // data byte index after which start is pulsed, -1 none
        logic              exp_err;
        int                exp_n;
        logic [ADDR_W-1:0] exp_final;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Writes, the ready-low rule in write cycles and continuous hold are watched on every falling edge.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            wr_log.push_back({bus.wr_addr, bus.wr_data});
            checks++;
            if (bus.in_ready) begin
                errors++;
                $display("FAIL ready_in_write actual=1 required=0");
            end
        end
        if (done) done_cnt++;
        if (loading) begin
            checks++;
            if (!cpu_hold) begin
                errors++;
                $display("FAIL hold_during_load actual=0 required=1");
            end
        end
    end

    // Offer one byte with optional random idle cycles. Return on the falling edge after it transfers.
    task automatic push_byte(input logic [7:0] b, input int gap);
        int guard;
        if (stalled) return;
        while (gap > 0 && $urandom_range(0, 99) < gap) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            stalled = 1'b1;
            bus.in_valid = 1'b0;
            $display("FAIL accept_timeout actual=no_ready required=ready byte=%0h", b);
            return;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] hdr, input logic [7:0] flip, input int gap,
                           input int mid, input logic exp_err, input int exp_n,
                           input logic [ADDR_W-1:0] exp_final);
        logic [7:0] cs, bv;
        int n, k;
        wr_log.delete();
        done_cnt = 0;
        // Junk offered while idle must not be consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        chk("idle_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        pulse_start();
        chk("hold_after_start", cpu_hold, 1);
        chk("err_cleared_by_start", err, 0);
        loading = 1'b1;
        n = (hdr[ADDR_W-1:0] == 0) ? DEPTH : int'(hdr[ADDR_W-1:0]);
        cs = hdr;
        push_byte(hdr, gap);
        k = 0;
        for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--) begin
                bv = wq[i][8*b +: 8];
                cs ^= bv;
                push_byte(bv, gap);
                if (k == mid) pulse_start();
                k++;
            end
        end
        push_byte(cs ^ flip, gap);
        chk("done_pulse", done, 1);
        chk("err_at_done", err, exp_err);
        chk("hold_at_done", cpu_hold, 1);
        chk("final_wr_addr", bus.wr_addr, exp_final);
        loading = 1'b0;
        @(negedge clk);
        chk("hold_released", cpu_hold, 0);
        chk("done_one_cycle", done, 0);
        chk("err_held", err, exp_err);
        chk("write_count", wr_log.size(), exp_n);
        for (int i = 0; i < wr_log.size() && i < n; i++)
            chk($sformatf("write_%0d", i), wr_log[i], {ADDR_W'(i), wq[i]});
        chk("done_count", done_cnt, 1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h02, 8'h00, 0,  2, -1, 1'b0, 2,   8'd2};
        vecs[1] = '{8'h02, 8'h01, 0,  2, -1, 1'b1, 2,   8'd2};
        vecs[2] = '{8'h03, 8'h00, 50, 0, -1, 1'b0, 3,   8'd3};
        vecs[3] = '{8'h01, 8'h80, 20, 0, -1, 1'b1, 1,   8'd1};
        vecs[4] = '{8'h00, 8'h00, 0,  1, -1, 1'b0, 256, 8'd0};
        vecs[5] = '{8'h05, 8'h00, 30, 0, 6,  1'b0, 5,   8'd5};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            wq.delete();
            for (int i = 0; i < vecs[v].exp_n; i++) begin
                case (vecs[v].pat)
                    1:       wq.push_back(32'(i));
                    2:       wq.push_back(i == 0 ? 32'h2421_0004 : 32'h8C22_0000);
                    default: wq.push_back($urandom);
                endcase
            end
            do_load(vecs[v].hdr, vecs[v].flip, vecs[v].gap, vecs[v].mid,
                    vecs[v].exp_err, vecs[v].exp_n, vecs[v].exp_final);
            if (vecs[v].exp_err) begin
                repeat (3) @(negedge clk);
                chk("err_sticky", err, 1);
            end
        end

        for (int r = 0; r < 4; r++) begin
            int n;
            logic [7:0] flip;
            n = $urandom_range(1, 6);
            flip = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            do_load(8'(n), flip, $urandom_range(0, 60), -1, flip != 8'h00, n, ADDR_W'(n));
        end

        // Async reset part-way through a word, between clock edges.
        pulse_start();
        push_byte(8'h03, 0);
        push_byte(8'h11, 0);
        push_byte(8'h22, 0);
        push_byte(8'h33, 0);
        push_byte(8'h44, 0);
        push_byte(8'h55, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu_hold", cpu_hold, 0);
        chk("arst_in_ready", bus.in_ready, 0);
        chk("arst_wr_addr", bus.wr_addr, 0);
        chk("arst_wr_data", bus.wr_data, 0);
        chk("arst_wr_en", bus.wr_en, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wq.delete();
        wq.push_back(32'hDEAD_BEEF);
        wq.push_back(32'h0123_4567);
        do_load(8'h02, 8'h00, 10, -1, 1'b0, 2, 8'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
